tt_mask_idx_streamer: RTL and testbench

//  Credit-based streamer feeding mask chunks and index elements of a vector memop to the LSU.

---
 rtl/tt_mask_idx_pkg.sv | 35 +++
 rtl/tt_credit_counter.sv | 43 ++++
 rtl/tt_mask_idx_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_tt_mask_idx_streamer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mask_idx_pkg.sv
// Shared types and helpers for the mask/index streamer.
// Optional build macro used by the top: TT_MASK_IDX_SKIP_INACTIVE_EN.
package tt_mask_idx_pkg;

    localparam int TT_VLEN = 256;
    localparam int TT_XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEW_8,
        SEW_16,
        SEW_32,
        SEW_64
    } sew_e;

    typedef struct packed {
        logic               mask;
        logic [TT_XLEN-1:0] payload;
    } item_t;

    function automatic int cred_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int elem_bits(input sew_e s);
        return 8 << s;
    endfunction

endpackage

// File: rtl/tt_credit_counter.sv
// LSU item credit pool: starts full, +1 per return, -1 per issued item.
// A return that would push the pool above CREDITS is flagged by an assertion.
module tt_credit_counter
    import tt_mask_idx_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_credit,
    input  logic i_consume,
    output logic o_avail
);

    localparam int CW = cred_w(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unique case ({i_credit, i_consume})
            2'b10: begin
                if (cnt_q == CW'(CREDITS)) ovf = 1'b1;
                else cnt_d = cnt_q + CW'(1);
            end
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cnt_q <= CW'(CREDITS);
        else cnt_q <= cnt_d;
    end

    assign o_avail = (cnt_q != '0);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset) !ovf)
        else $error("credit counter overflow");

endmodule

// File: rtl/tt_mask_idx_streamer.sv
// Credit-based streamer of v0 mask chunks / index elements to the LSU.
// TT_MASK_IDX_SKIP_INACTIVE_EN: masked indexed ops drop inactive elements.
module tt_mask_idx_streamer
    import tt_mask_idx_pkg::*;
#(
    parameter  int VLEN     = TT_VLEN,
    parameter  int XLEN     = TT_XLEN,
    parameter  int CREDITS  = 2,
    parameter  int IDX_REGS = 8,
    localparam int VLW      = $clog2(VLEN + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_is_masked,
    input  logic            i_is_indexed,
    input  logic [1:0]      i_sew,
    input  logic [VLW-1:0]  i_vl,
    input  logic [VLEN-1:0] i_mask_data,
    input  logic            i_mask_valid,
    input  logic [VLEN-1:0] i_idx_data,
    input  logic            i_idx_valid,
    input  logic            i_credit,
    output logic [XLEN:0]   o_item,
    output logic            o_item_valid,
    output logic            o_item_last,
    output logic            o_busy,
    output logic            o_done
);

    localparam int VB = $clog2(VLEN);
    localparam int PW = (IDX_REGS > 1) ? $clog2(IDX_REGS) : 1;

    state_e          state_q, state_d;
    logic            masked_q, masked_d, indexed_q, indexed_d;
    sew_e            sew_q, sew_d;
    logic [VLW-1:0]  vl_q, vl_d, elem_q, elem_d;
    logic [VLEN-1:0] mask_q, mask_d;
    logic            mask_vld_q, mask_vld_d;
    logic [VLEN-1:0] idx_q [IDX_REGS];
    logic [VLEN-1:0] idx_d [IDX_REGS];
    logic [IDX_REGS-1:0] idx_vld_q, idx_vld_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    item_t           item_q, item_d;
    logic            item_valid_q, item_valid_d;
    logic            item_last_q, item_last_d;
    logic            done_q, done_d;

    logic [VLW-1:0]  total;
    logic [31:0]     chunk_base, lim, bitpos, ridx, off;
    logic [PW-1:0]   rsel;
    logic [XLEN-1:0] chunk, keep, raw, wmask, pay;
    logic            ebit, data_rdy, skip, issue, last_item, avail;

    tt_credit_counter #(.CREDITS(CREDITS)) u_credits (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_credit (i_credit),
        .i_consume(issue),
        .o_avail  (avail)
    );

`ifdef TT_MASK_IDX_SKIP_INACTIVE_EN
    logic [VLEN:0]   vlm_w;
    logic [VLEN-1:0] act;
    logic            no_more;

    always_comb begin
        vlm_w   = ({{VLEN{1'b0}}, 1'b1} << vl_q) - {{VLEN{1'b0}}, 1'b1};
        act     = mask_q & vlm_w[VLEN-1:0];
        no_more = ((act >> (32'(elem_q) + 32'd1)) == '0);
    end
`endif

    // Item datapath: mask chunk k, or element e sliced out of its index reg
    always_comb begin
        total      = indexed_q ? vl_q : VLW'((32'(vl_q) + XLEN - 1) / XLEN);
        chunk_base = 32'(elem_q) * XLEN;
        chunk      = XLEN'(mask_q >> chunk_base);
        lim        = 32'(vl_q) - chunk_base;
        keep       = (lim >= 32'(XLEN)) ? '1 : (XLEN'(1) << lim) - XLEN'(1);
        bitpos     = 32'(elem_q) << (32'(sew_q) + 32'd3);
        ridx       = bitpos / 32'(VLEN);
        off        = bitpos % 32'(VLEN);
        rsel       = (ridx >= 32'(IDX_REGS)) ? PW'(IDX_REGS - 1) : PW'(ridx);
        raw        = XLEN'(idx_q[rsel] >> off);
        wmask      = (elem_bits(sew_q) >= XLEN) ? '1
                   : (XLEN'(1) << elem_bits(sew_q)) - XLEN'(1);
        ebit       = mask_q[elem_q[VB-1:0]];
        data_rdy   = !indexed_q || idx_vld_q[rsel];
        pay        = indexed_q ? (raw & wmask) : (chunk & keep);
`ifdef TT_MASK_IDX_SKIP_INACTIVE_EN
        skip       = indexed_q && masked_q && !ebit;
        last_item  = (indexed_q && masked_q) ? no_more : (elem_q == total - VLW'(1));
`else
        skip       = 1'b0;
        last_item  = (elem_q == total - VLW'(1));
`endif
        issue      = (state_q == ST_SEND) && !skip && avail && data_rdy;
    end

    always_comb begin
        state_d      = state_q;
        masked_d     = masked_q;
        indexed_d    = indexed_q;
        sew_d        = sew_q;
        vl_d         = vl_q;
        elem_d       = elem_q;
        mask_d       = mask_q;
        mask_vld_d   = mask_vld_q;
        idx_d        = idx_q;
        idx_vld_d    = idx_vld_q;
        wptr_d       = wptr_q;
        item_d       = '0;
        item_valid_d = 1'b0;
        item_last_d  = 1'b0;
        done_d       = (state_q == ST_DONE);
        if (state_q == ST_LOAD || state_q == ST_SEND) begin
            if (i_mask_valid) begin
                mask_d     = i_mask_data;
                mask_vld_d = 1'b1;
            end
            if (i_idx_valid) begin
                idx_d[wptr_q]     = i_idx_data;
                idx_vld_d[wptr_q] = 1'b1;
                if (wptr_q != PW'(IDX_REGS - 1)) wptr_d = wptr_q + PW'(1);
            end
        end
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    masked_d   = i_is_masked;
                    indexed_d  = i_is_indexed;
                    sew_d      = sew_e'(i_sew);
                    vl_d       = i_vl;
                    elem_d     = '0;
                    mask_vld_d = 1'b0;
                    idx_vld_d  = '0;
                    wptr_d     = '0;
                    state_d    = (i_vl == '0 || (!i_is_masked && !i_is_indexed))
                               ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: if (!masked_q || mask_vld_q) state_d = ST_SEND;
            ST_SEND: begin
                if (skip) begin
                    elem_d = elem_q + VLW'(1);
                    if (elem_q == total - VLW'(1)) state_d = ST_DONE;
                end else if (issue) begin
                    elem_d         = elem_q + VLW'(1);
                    item_valid_d   = 1'b1;
                    item_last_d    = last_item;
                    item_d.mask    = indexed_q && (!masked_q || ebit);
                    item_d.payload = pay;
                    if (last_item) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            masked_q     <= 1'b0;
            indexed_q    <= 1'b0;
            sew_q        <= SEW_8;
            vl_q         <= '0;
            elem_q       <= '0;
            mask_q       <= '0;
            mask_vld_q   <= 1'b0;
            idx_q        <= '{default: '0};
            idx_vld_q    <= '0;
            wptr_q       <= '0;
            item_q       <= '0;
            item_valid_q <= 1'b0;
            item_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            masked_q     <= masked_d;
            indexed_q    <= indexed_d;
            sew_q        <= sew_d;
            vl_q         <= vl_d;
            elem_q       <= elem_d;
            mask_q       <= mask_d;
            mask_vld_q   <= mask_vld_d;
            idx_q        <= idx_d;
            idx_vld_q    <= idx_vld_d;
            wptr_q       <= wptr_d;
            item_q       <= item_d;
            item_valid_q <= item_valid_d;
            item_last_q  <= item_last_d;
            done_q       <= done_d;
        end
    end

    assign o_item       = item_q;
    assign o_item_valid = item_valid_q;
    assign o_item_last  = item_last_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;

endmodule

// File: tb/tb_tt_mask_idx_streamer.sv
// Directed bench for tt_mask_idx_streamer (VLEN=256, XLEN=64, CREDITS=2).
// Items are captured at negedge; credits are returned one cycle after each item.
module tb_tt_mask_idx_streamer;

    localparam int VLEN = 256;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            i_reset, i_start, i_is_masked, i_is_indexed;
    logic [1:0]      i_sew;
    logic [8:0]      i_vl;
    logic [VLEN-1:0] i_mask_data, i_idx_data;
    logic            i_mask_valid, i_idx_valid, i_credit;
    logic [XLEN:0]   o_item;
    logic            o_item_valid, o_item_last, o_busy, o_done;

    logic auto_en = 1'b0, auto_ret = 1'b0, man_credit = 1'b0;
    assign i_credit = auto_ret | man_credit;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -1;
    logic [XLEN:0] q_item [$];
    logic          q_last [$];

    logic [VLEN-1:0] m_pat;

    always #5 clk = ~clk;

    tt_mask_idx_streamer dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_is_masked(i_is_masked), .i_is_indexed(i_is_indexed),
        .i_sew(i_sew), .i_vl(i_vl),
        .i_mask_data(i_mask_data), .i_mask_valid(i_mask_valid),
        .i_idx_data(i_idx_data), .i_idx_valid(i_idx_valid),
        .i_credit(i_credit), .o_item(o_item), .o_item_valid(o_item_valid),
        .o_item_last(o_item_last), .o_busy(o_busy), .o_done(o_done)
    );

    always @(negedge clk) begin
        cyc++;
        auto_ret = auto_en && o_item_valid;
        if (o_item_valid) begin
            q_item.push_back(o_item);
            q_last.push_back(o_item_last);
            if (o_item_last) last_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_cap();
        q_item.delete();
        q_last.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_cyc = -1;
    endtask

    task automatic start_op(input logic m, input logic x, input logic [1:0] s, input int vl);
        i_is_masked  = m;
        i_is_indexed = x;
        i_sew        = s;
        i_vl         = 9'(vl);
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic put_mask(input logic [VLEN-1:0] d);
        i_mask_data  = d;
        i_mask_valid = 1'b1;
        tick();
        i_mask_valid = 1'b0;
    endtask

    task automatic put_idx(input logic [VLEN-1:0] d);
        i_idx_data  = d;
        i_idx_valid = 1'b1;
        tick();
        i_idx_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: done not seen, items=%0d", nm, q_item.size());
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 0; i_is_masked = 0; i_is_indexed = 0; i_sew = 0; i_vl = 0;
        i_mask_data = '0; i_mask_valid = 0; i_idx_data = '0; i_idx_valid = 0;
        repeat (3) tick();
        checks += 5;
        if (o_item !== '0) begin errors++; $display("FAIL rst_item: got %h want 0", o_item); end
        if (o_item_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_item_valid); end
        if (o_item_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", o_item_last); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", o_done); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_mask_mode();
        logic [XLEN:0] exp [3];
        exp[0] = {1'b0, 64'h0123456789ABCDEF};
        exp[1] = {1'b0, 64'hFEDCBA9876543210};
        exp[2] = {1'b0, 64'h0000000000000003};
        auto_en = 1'b1;
        clear_cap();
        start_op(1, 0, 0, 130);
        put_mask(m_pat);
        wait_done("mask");
        checks++;
        if (q_item.size() != 3) begin
            errors++; $display("FAIL mask_count: got %0d want 3", q_item.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks += 2;
                if (q_item[k] !== exp[k]) begin
                    errors++; $display("FAIL mask_item%0d: got %h want %h", k, q_item[k], exp[k]);
                end
                if (q_last[k] !== (k == 2)) begin
                    errors++; $display("FAIL mask_last%0d: got %b want %b", k, q_last[k], k == 2);
                end
            end
        end
        checks += 2;
        if (done_cyc != last_cyc + 1) begin
            errors++; $display("FAIL mask_done_lat: done cyc %0d last cyc %0d", done_cyc, last_cyc);
        end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL mask_idle: busy %b want 0", o_busy); end
    endtask

    task automatic test_credits();
        auto_en = 1'b0;
        clear_cap();
        start_op(1, 0, 0, 256);
        put_mask(m_pat);
        repeat (20) tick();
        checks += 2;
        if (q_item.size() != 2) begin errors++; $display("FAIL cred_stall: got %0d items want 2", q_item.size()); end
        if (o_busy !== 1'b1) begin errors++; $display("FAIL cred_busy: got %b want 1", o_busy); end
        man_credit = 1'b1;
        tick();
        man_credit = 1'b0;
        repeat (10) tick();
        checks++;
        if (q_item.size() != 3) begin
            errors++; $display("FAIL cred_one_more: got %0d items want 3", q_item.size());
        end else begin
            checks++;
            if (q_item[2] !== {1'b0, 64'hFFFFFFFFFFFFFFFF}) begin
                errors++; $display("FAIL cred_item2: got %h want %h", q_item[2], {1'b0, 64'hFFFFFFFFFFFFFFFF});
            end
        end
        man_credit = 1'b1;
        tick();
        man_credit = 1'b0;
        wait_done("cred");
        checks++;
        if (q_item.size() != 4) begin
            errors++; $display("FAIL cred_total: got %0d items want 4", q_item.size());
        end else begin
            checks += 2;
            if (q_item[3] !== {1'b0, 64'h5555555555555555}) begin
                errors++; $display("FAIL cred_item3: got %h want %h", q_item[3], {1'b0, 64'h5555555555555555});
            end
            if (q_last[3] !== 1'b1 || q_last[2] !== 1'b0) begin
                errors++; $display("FAIL cred_last: got %b%b want 01", q_last[2], q_last[3]);
            end
        end
        man_credit = 1'b1;
        tick();
        tick();
        man_credit = 1'b0;
        auto_en = 1'b1;
    endtask

    task automatic test_indexed_sew16();
        logic [VLEN-1:0] r0, r1;
        logic [15:0]     v;
        r0 = '0;
        r1 = '0;
        for (int e = 0; e < 20; e++) begin
            v = 16'hA000 + 16'(e) * 16'h0111;
            if (e < 16) r0[e*16 +: 16] = v;
            else r1[(e-16)*16 +: 16] = v;
        end
        clear_cap();
        start_op(0, 1, 1, 20);
        put_idx(r0);
        put_idx(r1);
        wait_done("sew16");
        checks++;
        if (q_item.size() != 20) begin
            errors++; $display("FAIL sew16_count: got %0d want 20", q_item.size());
        end else begin
            for (int e = 0; e < 20; e++) begin
                v = 16'hA000 + 16'(e) * 16'h0111;
                checks += 2;
                if (q_item[e] !== {1'b1, 48'h0, v}) begin
                    errors++; $display("FAIL sew16_item%0d: got %h want %h", e, q_item[e], {1'b1, 48'h0, v});
                end
                if (q_last[e] !== (e == 19)) begin
                    errors++; $display("FAIL sew16_last%0d: got %b want %b", e, q_last[e], e == 19);
                end
            end
        end
    endtask

    task automatic test_idx_late();
        logic [VLEN-1:0] r0, r1;
        for (int e = 0; e < 4; e++) begin
            r0[e*64 +: 64] = 64'hDEADBEEF00000000 | 64'(e);
            r1[e*64 +: 64] = 64'hDEADBEEF00000000 | 64'(e + 4);
        end
        clear_cap();
        start_op(0, 1, 3, 8);
        put_idx(r0);
        repeat (10) tick();
        checks++;
        if (q_item.size() != 4) begin errors++; $display("FAIL late_stall: got %0d items want 4", q_item.size()); end
        put_idx(r1);
        wait_done("late");
        checks++;
        if (q_item.size() != 8) begin
            errors++; $display("FAIL late_count: got %0d want 8", q_item.size());
        end else begin
            for (int e = 0; e < 8; e++) begin
                checks += 2;
                if (q_item[e] !== {1'b1, 64'hDEADBEEF00000000 | 64'(e)}) begin
                    errors++; $display("FAIL late_item%0d: got %h want %h", e, q_item[e], {1'b1, 64'hDEADBEEF00000000 | 64'(e)});
                end
                if (q_last[e] !== (e == 7)) begin
                    errors++; $display("FAIL late_last%0d: got %b want %b", e, q_last[e], e == 7);
                end
            end
        end
    endtask

    task automatic test_masked_indexed();
        logic [VLEN-1:0] r0;
        r0 = '0;
        for (int e = 0; e < 4; e++) r0[e*8 +: 8] = 8'h10 + 8'(e);
        clear_cap();
        start_op(1, 1, 0, 4);
        i_mask_data  = 256'h5;
        i_mask_valid = 1'b1;
        i_idx_data   = r0;
        i_idx_valid  = 1'b1;
        tick();
        i_mask_valid = 1'b0;
        i_idx_valid  = 1'b0;
        wait_done("midx");
`ifdef TT_MASK_IDX_SKIP_INACTIVE_EN
        checks++;
        if (q_item.size() != 2) begin
            errors++; $display("FAIL midx_count: got %0d want 2", q_item.size());
        end else begin
            checks += 3;
            if (q_item[0] !== {1'b1, 64'h10}) begin errors++; $display("FAIL midx_item0: got %h want %h", q_item[0], {1'b1, 64'h10}); end
            if (q_item[1] !== {1'b1, 64'h12}) begin errors++; $display("FAIL midx_item1: got %h want %h", q_item[1], {1'b1, 64'h12}); end
            if (q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin
                errors++; $display("FAIL midx_last: got %b%b want 01", q_last[0], q_last[1]);
            end
        end
`else
        checks++;
        if (q_item.size() != 4) begin
            errors++; $display("FAIL midx_count: got %0d want 4", q_item.size());
        end else begin
            for (int e = 0; e < 4; e++) begin
                checks += 2;
                if (q_item[e] !== {(e % 2 == 0), 64'(8'h10 + e)}) begin
                    errors++; $display("FAIL midx_item%0d: got %h want %h", e, q_item[e], {(e % 2 == 0), 64'(8'h10 + e)});
                end
                if (q_last[e] !== (e == 3)) begin
                    errors++; $display("FAIL midx_last%0d: got %b want %b", e, q_last[e], e == 3);
                end
            end
        end
`endif
    endtask

    task automatic test_empty();
        clear_cap();
        start_op(1, 0, 0, 0);
        wait_done("vl0");
        checks++;
        if (q_item.size() != 0) begin errors++; $display("FAIL vl0_items: got %0d want 0", q_item.size()); end
        clear_cap();
        start_op(0, 0, 0, 5);
        wait_done("plain");
        checks += 2;
        if (q_item.size() != 0) begin errors++; $display("FAIL plain_items: got %0d want 0", q_item.size()); end
        if (done_cnt != 1) begin errors++; $display("FAIL plain_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        auto_en = 1'b0;
        clear_cap();
        start_op(1, 0, 0, 256);
        put_mask(m_pat);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_item_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rmid_timeout: no item before reset"); end
        #1 i_reset = 1'b1;
        #1;
        checks += 4;
        if (o_item_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", o_item_valid); end
        if (o_item !== '0) begin errors++; $display("FAIL rmid_item: got %h want 0", o_item); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
        if (o_item_last !== 1'b0) begin errors++; $display("FAIL rmid_last: got %b want 0", o_item_last); end
        @(negedge clk);
        i_reset = 1'b0;
        clear_cap();
        repeat (5) tick();
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL rmid_nodone: got %0d pulses want 0", done_cnt); end
        clear_cap();
        start_op(1, 0, 0, 128);
        put_mask(m_pat);
        wait_done("rmid");
        checks++;
        if (q_item.size() != 2) begin
            errors++; $display("FAIL rmid_count: got %0d want 2", q_item.size());
        end else begin
            checks += 2;
            if (q_item[1] !== {1'b0, 64'hFEDCBA9876543210}) begin
                errors++; $display("FAIL rmid_item1: got %h want %h", q_item[1], {1'b0, 64'hFEDCBA9876543210});
            end
            if (q_last[1] !== 1'b1) begin errors++; $display("FAIL rmid_last1: got %b want 1", q_last[1]); end
        end
        man_credit = 1'b1;
        tick();
        tick();
        man_credit = 1'b0;
        auto_en = 1'b1;
    endtask

    initial begin
        m_pat = {64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF,
                 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        test_reset();
        test_mask_mode();
        test_credits();
        test_indexed_sew16();
        test_idx_late();
        test_masked_indexed();
        test_empty();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
